lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Load/store control stage between the EX/MEM pipeline register and the DataMemory block.
- Accepts one LDUR/STUR request at a time and checks alignment and range.
- Drives registered read/write strobes into DataMemory, absorbs its one-cycle registered read latency, and returns load data to writeback.
- Stalls upstream while an access is in flight.

Parameters:
- DATA_W, 64, register/data width; matches `REGDATASIZE.
- MEM_WORDS, 1024, number of 64-bit words in DataMemory; legal byte addresses are 0 .. MEM_WORDS*8-8.
- RD_W, 5, destination register index width.

Ports:
- mem_clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of mem_clk.
- ex_valid  in  1  request valid from EX/MEM.
- ex_ready  out  1  stage can accept a request this cycle.
- ex_is_load  in  1  request is LDUR.
- ex_is_store  in  1  request is STUR.
- ex_addr  in  DATA_W  byte address.
- ex_store_data  in  DATA_W  STUR data.
- ex_rd  in  RD_W  LDUR destination register.
- dm_read_enable  out  1  registered DataMemory read strobe.
- dm_write_enable  out  1  registered DataMemory write strobe.
- dm_addr  out  DATA_W  registered byte address to DataMemory.
- dm_write_data  out  DATA_W  registered store data.
- dm_read_data  in  DATA_W  DataMemory registered read output.
- wb_valid  out  1  one-cycle pulse: load result ready.
- wb_rd  out  RD_W  load destination.
- wb_data  out  DATA_W  load result.
- fault  out  1  one-cycle pulse: request rejected.
- fault_addr  out  DATA_W  address of the last faulting request; holds until the next fault.
- pipe_stall  out  1  equals ex_valid & ~ex_ready; combinational.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE.
  - All registered outputs are 0: dm_*, wb_*, fault, fault_addr.
  - Reset overrides any in-flight access. An aborted load never raises wb_valid.
- States: IDLE, LOAD_ISSUE, LOAD_DATA, STORE_ISSUE. ex_ready=1 only in IDLE.
- Accept = ex_valid & ex_ready at an edge.
- Request is legal iff all of the following hold:
  - addr[2:0]==0;
  - addr < MEM_WORDS*8 (full DATA_W compare, no truncation);
  - exactly one of ex_is_load / ex_is_store is set.
- Accepted, both flags 0: no-op. No memory access, no fault, stays IDLE.
- Accepted, illegal (both flags set, or bad address):
  - next cycle fault=1 and fault_addr=ex_addr;
  - stays IDLE; dm strobes stay 0.
- Accepted legal load:
  - Latch addr and rd.
  - LOAD_ISSUE (1 cycle): dm_read_enable=1, dm_addr=addr.
  - LOAD_DATA (1 cycle): dm_read_enable=0; dm_read_data is valid.
  - At the end of LOAD_DATA: wb_data<=dm_read_data, wb_rd<=rd, wb_valid<=1; return to IDLE.
  - Latency: accept edge T -> wb_valid high in cycle T+3. ex_ready low for 2 cycles.
- Accepted legal store:
  - STORE_ISSUE (1 cycle): dm_write_enable=1, dm_addr, dm_write_data driven; then IDLE.
  - ex_ready low for 1 cycle. No wb_valid.
- wb_valid and fault are single-cycle pulses; wb_data and wb_rd hold their value after the pulse.
- dm_read_enable and dm_write_enable are never high in the same cycle.
- dm_addr and dm_write_data hold their last value when strobes are low.
- A new request may be accepted in the same cycle wb_valid pulses, since state is IDLE.
- Store followed by load to the same address is strictly ordered. No forwarding is needed.
- ex_* inputs are ignored while ex_ready=0. Upstream must hold them stable while pipe_stall=1.

Decomposition:
- Package lsu_pkg holds:
  - state enum lsu_state_t {IDLE, LOAD_ISSUE, LOAD_DATA, STORE_ISSUE};
  - localparam WORD_BYTES=8;
  - ALIGN_MASK=3'b111.
- Sub-module lsu_addr_check: combinational legality check with inputs addr, is_load, is_store and output illegal, parameterised by MEM_WORDS. The FSM and registers stay in lsu_mem_stage.

Test Plan:
- Preload mem[2]=64'hDEADBEEF; load addr 0x10, rd=7 accepted at edge T -> dm_read_enable high in cycle T+1 only; wb_valid=1, wb_rd=7, wb_data=64'hDEADBEEF in cycle T+3; ex_ready low in cycles T+1..T+2.
- Store addr 0x18 data 64'h1234, then immediately load 0x18 rd=3 -> dm_write_enable one cycle; load returns wb_data=64'h1234, wb_rd=3.
- Load addr 0x0C -> fault=1 for one cycle, fault_addr=0x0C, no dm strobe, ex_ready stays 1. Load addr 0x2000 (=MEM_WORDS*8) -> same fault. Request with both flags set -> fault.
- ex_valid held high with two back-to-back loads -> pipe_stall=1 for 2 cycles per load; second load accepted in the cycle the first wb_valid pulses; results in order.
- reset driven 0 for one edge while in LOAD_DATA -> next cycle state IDLE, wb_valid never pulses, all dm strobes 0, ex_ready=1.
- ex_valid=1 with neither flag set -> accepted, no strobe, no fault, no wb_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_ISSUE,
        LOAD_DATA,
        STORE_ISSUE
    } lsu_state_t;

    localparam int         WORD_BYTES = 8;
    localparam logic [2:0] ALIGN_MASK = 3'b111;

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational legality check for one LDUR/STUR request: word alignment,
// full-width range check and exactly one of load/store.
module lsu_addr_check
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 1024
) (
    input  logic [DATA_W-1:0] addr,
    input  logic              is_load,
    input  logic              is_store,
    output logic              illegal
);

    // Compared at full width so large addresses never alias into range.
    localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(MEM_WORDS * WORD_BYTES);

    logic misaligned;
    logic out_of_range;
    logic bad_kind;

    assign misaligned   = (addr[2:0] & ALIGN_MASK) != 3'b000;
    assign out_of_range = addr >= ADDR_LIMIT;
    assign bad_kind     = ~(is_load ^ is_store);
    assign illegal      = misaligned | out_of_range | bad_kind;

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store control stage between EX/MEM and DataMemory: issues registered
// strobes, absorbs the one-cycle read latency and returns load data.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 1024,
    parameter int RD_W      = 5
) (
    input  logic              mem_clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [RD_W-1:0]   ex_rd,
    output logic              dm_read_enable,
    output logic              dm_write_enable,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_write_data,
    input  logic [DATA_W-1:0] dm_read_data,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fault,
    output logic [DATA_W-1:0] fault_addr,
    output logic              pipe_stall,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge where ex_valid and
    // ex_ready are both 1; ex_ready is 1 only in IDLE, and while
    // pipe_stall is 1 upstream holds ex_* stable.

    lsu_state_t      state_q, state_d;
    logic [RD_W-1:0] rd_q;
    logic            illegal;
    logic            accept;
    logic            no_op;
    logic            issue_load;
    logic            issue_store;
    logic            reject;

    lsu_addr_check #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_addr_check (
        .addr     (ex_addr),
        .is_load  (ex_is_load),
        .is_store (ex_is_store),
        .illegal  (illegal)
    );

    always_comb begin
        state_d     = state_q;
        ex_ready    = (state_q == IDLE);
        accept      = ex_valid & ex_ready;
        no_op       = ~ex_is_load & ~ex_is_store;
        issue_load  = accept & ~no_op & ~illegal & ex_is_load;
        issue_store = accept & ~no_op & ~illegal & ex_is_store;
        reject      = accept & ~no_op & illegal;
        case (state_q)
            IDLE: begin
                if (issue_load) begin
                    state_d = LOAD_ISSUE;
                end else if (issue_store) begin
                    state_d = STORE_ISSUE;
                end
            end
            LOAD_ISSUE:  state_d = LOAD_DATA;
            LOAD_DATA:   state_d = IDLE;
            STORE_ISSUE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            rd_q            <= '0;
            dm_read_enable  <= 1'b0;
            dm_write_enable <= 1'b0;
            dm_addr         <= '0;
            dm_write_data   <= '0;
            wb_valid        <= 1'b0;
            wb_rd           <= '0;
            wb_data         <= '0;
            fault           <= 1'b0;
            fault_addr      <= '0;
        end else begin
            state_q         <= state_d;
            dm_read_enable  <= issue_load;
            dm_write_enable <= issue_store;
            if (issue_load || issue_store) begin
                dm_addr <= ex_addr;
            end
            if (issue_store) begin
                dm_write_data <= ex_store_data;
            end
            if (issue_load) begin
                rd_q <= ex_rd;
            end
            // DataMemory output is valid during LOAD_DATA.
            wb_valid <= (state_q == LOAD_DATA);
            if (state_q == LOAD_DATA) begin
                wb_data <= dm_read_data;
                wb_rd   <= rd_q;
            end
            fault <= reject;
            if (reject) begin
                fault_addr <= ex_addr;
            end
        end
    end

    assign pipe_stall = ex_valid & ~ex_ready;
    assign dbg_state  = state_q;

endmodule
